fetch_unit: RTL

//  Instruction fetch stage: owns the PC, drives the byte address of the combinational

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/fetch_buf.sv | 85 ++++++++
 rtl/fetch_unit.sv | 92 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage.
//   INSTR_W        : instruction word width
//   RESET_PC_DEF   : default PC loaded on reset
//   IMEM_BYTES_DEF : default instruction memory size in bytes
//   NOP            : canonical no-op encoding (addi x0,x0,0)
//   fetch_entry_t  : one buffered fetch record {pc, instr}
package cpu_pkg;

  localparam int          INSTR_W        = 32;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_0000;
  localparam int          IMEM_BYTES_DEF = 1024;
  localparam logic [31:0] NOP            = 32'h0000_0013;

  typedef struct packed {
    logic [31:0]        pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Word-align a byte address by clearing the two low bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // True when the word at pc does not fit entirely inside memory.
  // Done in 33 bits so pc values near 2^32 cannot wrap back into range.
  function automatic logic beyond_imem(input logic [31:0] pc, input logic [32:0] limit);
    return (({1'b0, pc} + 33'd3) >= limit);
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry synchronous FIFO holding {pc, instr} fetch records.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write din at the tail (ignored when full without pop)
//   pop        : discard the head (ignored when empty)
//   flush      : empty the FIFO; overrides push and pop in the same cycle
//   din        : record to write, {pc[31:0], instr[31:0]}
//   dout       : head record, zero when empty
//   count      : occupancy 0..2
module fetch_buf
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push,
  input  logic        pop,
  input  logic        flush,
  input  logic [63:0] din,
  output logic [63:0] dout,
  output logic [1:0]  count
);

  logic [63:0] entry_r [2];
  logic        rd_ptr_r;
  logic        wr_ptr_r;
  logic [1:0]  count_r;
  logic        do_pop_s;
  logic        do_push_s;

  // Guard the requests so a misbehaving caller cannot over- or under-run.
  always_comb begin
    do_pop_s  = 1'b0;
    do_push_s = 1'b0;
    if (pop && (count_r != 2'd0)) begin
      do_pop_s = 1'b1;
    end else begin
      do_pop_s = 1'b0;
    end
    if (push && ((count_r != 2'd2) || do_pop_s)) begin
      do_push_s = 1'b1;
    end else begin
      do_push_s = 1'b0;
    end
  end

  // Storage, pointers and occupancy; flush wins over any push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_r[0] <= 64'd0;
      entry_r[1] <= 64'd0;
      rd_ptr_r   <= 1'b0;
      wr_ptr_r   <= 1'b0;
      count_r    <= 2'd0;
    end else if (flush) begin
      rd_ptr_r <= 1'b0;
      wr_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        entry_r[wr_ptr_r] <= din;
        wr_ptr_r          <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Head record, forced to zero when nothing is buffered.
  always_comb begin
    dout = 64'd0;
    if (count_r != 2'd0) begin
      dout = entry_r[rd_ptr_r];
    end else begin
      dout = 64'd0;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. Owns the PC, addresses a combinational instruction
// memory, buffers up to two {pc, instr} records and hands them to decode.
//   clk, rst_n     : clock, asynchronous active-low reset
//   imem_addr      : byte address to instruction memory (= pc)
//   imem_rdata     : word at imem_addr, same cycle
//   redirect_valid : load redirect_pc (low bits masked), flush buffer, clear fault
//   redirect_pc    : redirect target
//   instr_valid    : buffer head is valid
//   instr_ready    : decode takes the head this cycle
//   instr          : head instruction (0 when empty)
//   instr_pc       : head PC (0 when empty)
//   fetch_fault    : sticky, PC left the memory; fetching halted
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int          IMEM_BYTES = IMEM_BYTES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [31:0]        imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  output logic               fetch_fault
);

  localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_BYTES);

  logic [31:0]  pc_r;
  logic         fault_r;
  logic         push_s;
  logic         pop_s;
  logic         out_of_range_s;
  logic [1:0]   count_s;
  fetch_entry_t din_s;
  fetch_entry_t head_s;

  assign imem_addr      = pc_r;
  assign instr_valid    = (count_s != 2'd0);
  assign instr          = head_s.instr;
  assign instr_pc       = head_s.pc;
  assign fetch_fault    = fault_r;
  assign pop_s          = instr_valid && instr_ready;
  assign out_of_range_s = beyond_imem(pc_r, IMEM_LIMIT);
  assign din_s          = '{pc: pc_r, instr: imem_rdata};

  // Fetch a word whenever there is (or will be) room, unless halted or redirecting.
  always_comb begin
    push_s = 1'b0;
    if (!fault_r && !redirect_valid && !out_of_range_s &&
        ((count_s != 2'd2) || pop_s)) begin
      push_s = 1'b1;
    end else begin
      push_s = 1'b0;
    end
  end

  // PC and sticky fault; a redirect overrides both and clears the fault.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_r    <= RESET_PC;
      fault_r <= 1'b0;
    end else if (redirect_valid) begin
      pc_r    <= align_word(redirect_pc);
      fault_r <= 1'b0;
    end else begin
      if (push_s) begin
        pc_r <= pc_r + 32'd4;
      end
      if (out_of_range_s) begin
        fault_r <= 1'b1;
      end
    end
  end

  fetch_buf u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (redirect_valid),
    .din   (din_s),
    .dout  (head_s),
    .count (count_s)
  );

endmodule
